node_info_ctrl: RTL and testbench
=================================

// Module: node_info_ctrl
// PURPOSE
//  Parametrised per-node information and state controller for the EER-RL sensor node.
//  - Decodes received control packets (fPktType) and tracks the node's routing state:
//    hops-to-sink (minimum seen), cluster role, TDMA timeslot and energy threshold.
//  - Raises a low-energy flag with hysteresis and produces a pipelined Q-value for the RL router.
//  - Sits between the packet parser (source of en_MNI/fPktType/fields) and the routing/MAC logic.
// PARAMETERS
//  DATA_W     16       width of energy, ID, hops, timeslot and Q fields
//  NODE_ID    16'h000C this node's ID (DATA_W bits)
//  THR_SHIFT  2        threshold = e_min + ((e_max - e_min) >> THR_SHIFT)
//  HYST       8        low_E clears only when energy >= e_thr + HYST
//  Q_SHIFT    4        Q = sat0((energy >> Q_SHIFT) - hopsFromSink)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  en_MNI        in   1       packet fields valid this cycle
//  fPktType      in   3       000 HELLO, 001 CH_ANN, 010 SCHED, 011 EBOUND, 111 NEW_ROUND; others ignored
//  e_max         in   DATA_W  network max energy (EBOUND)
//  e_min         in   DATA_W  network min energy (EBOUND)
//  energy        in   DATA_W  this node's residual energy, sampled every cycle
//  ch_ID         in   DATA_W  announced cluster-head ID (CH_ANN)
//  hops          in   DATA_W  sender's hop count (HELLO)
//  timeslot      in   DATA_W  assigned slot (SCHED)
//  myNodeID      out  DATA_W  constant NODE_ID
//  hopsFromSink  out  DATA_W  min(hops+1) seen; reset all-ones
//  myQValue      out  DATA_W  pipelined Q-value; reset 0
//  myTimeslot    out  DATA_W  latched slot; reset 0
//  e_thr         out  DATA_W  current energy threshold; reset 0
//  role          out  1       1 = cluster head; reset 0
//  low_E         out  1       low-energy flag; reset 0
//  state         out  2       FSM state; reset 0 (IDLE)
//  q_valid       out  1       1-cycle pulse when myQValue updates; reset 0
// BEHAVIOUR
//  - rst asserted: all registers take their reset values immediately, including mid-pipeline.
//  - Packets are acted on only when en_MNI=1; one packet per cycle; all updates are registered (1 clk).
//  - FSM: IDLE(0), DISC(1), CLUS(2), SCHED(3).
//    IDLE -HELLO accepted-> DISC; DISC -CH_ANN-> CLUS; CLUS -SCHED-> SCHED;
//    NEW_ROUND in DISC/CLUS/SCHED -> DISC (role<=0, myTimeslot<=0, hopsFromSink kept).
//    Packets not listed for the current state leave the state unchanged and have no side effect,
//    except HELLO and EBOUND, which are processed in every state.
//  - HELLO: accepted iff hops != all-ones and hops+1 < hopsFromSink; then hopsFromSink <= hops+1.
//  - CH_ANN (DISC only): role <= (ch_ID == NODE_ID).
//  - SCHED (CLUS only): myTimeslot <= timeslot. In SCHED state, further SCHED packets are ignored.
//  - EBOUND: e_thr <= (e_max >= e_min) ? e_min + ((e_max - e_min) >> THR_SHIFT) : e_min.
//  - low_E, evaluated every cycle regardless of en_MNI:
//    set when energy < e_thr; clear when energy >= sat(e_thr + HYST); otherwise hold.
//    sat() clamps to all-ones.
//  - Q pipeline trigger = accepted HELLO | EBOUND | low_E change.
//    Stage 1 (edge after trigger) latches energy and the updated hopsFromSink.
//    Stage 2 (next edge) writes myQValue and pulses q_valid.
//    Total latency is 2 clocks from the trigger cycle. Back-to-back triggers are accepted every cycle.
//    If hopsFromSink == all-ones, Q = 0.
//  - Q arithmetic: DATA_W unsigned. Subtraction saturates at 0.
// TESTING
//  1 Reset: assert rst mid-run -> all outputs reset (hopsFromSink=FFFF, state=0), asynchronously.
//  2 HELLO hops=3, then hops=5, then hops=1 -> hopsFromSink goes 4, stays 4, then 2.
//    state IDLE->DISC on the first; q_valid fires 2 clks after each accepted HELLO.
//  3 CH_ANN ch_ID=000C in DISC -> role=1, state=CLUS.
//    NEW_ROUND -> role=0, state=DISC.
//    CH_ANN ch_ID=0005 -> role=0, state=CLUS.
//  4 SCHED timeslot=7 in CLUS -> myTimeslot=7, state=SCHED.
//    SCHED in IDLE -> ignored. SCHED timeslot=9 while in SCHED -> ignored, myTimeslot stays 7.
//  5 EBOUND e_max=1000,e_min=200 -> e_thr=400.
//    energy 399 -> low_E=1; energy 405 -> stays 1; energy 408 -> low_E=0.
//    e_max<e_min -> e_thr=e_min.
//  6 energy=0x0100, hopsFromSink=2, Q_SHIFT=4 -> myQValue=14.
//    energy=0x0010, hopsFromSink=5 -> myQValue=0 (saturation).

Source files
------------

// File: rtl/node_info_ctrl.sv
// Per-node routing state, energy threshold/low-energy flag and pipelined Q-value for the RL router.
// Latency: state/field updates 1 clk; myQValue/q_valid 2 clks after trigger. No backpressure (one packet per cycle).
module node_info_ctrl #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] NODE_ID   = 16'h000C,
  parameter int                THR_SHIFT = 2,
  parameter int                HYST      = 8,
  parameter int                Q_SHIFT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_MNI,
  input  logic [2:0]        fPktType,
  input  logic [DATA_W-1:0] e_max,
  input  logic [DATA_W-1:0] e_min,
  input  logic [DATA_W-1:0] energy,
  input  logic [DATA_W-1:0] ch_ID,
  input  logic [DATA_W-1:0] hops,
  input  logic [DATA_W-1:0] timeslot,
  output logic [DATA_W-1:0] myNodeID,
  output logic [DATA_W-1:0] hopsFromSink,
  output logic [DATA_W-1:0] myQValue,
  output logic [DATA_W-1:0] myTimeslot,
  output logic [DATA_W-1:0] e_thr,
  output logic              role,
  output logic              low_E,
  output logic [1:0]        state,
  output logic              q_valid
);

  localparam logic [DATA_W-1:0] ONES = '1;
  localparam logic [2:0] PKT_HELLO = 3'b000;
  localparam logic [2:0] PKT_CHANN = 3'b001;
  localparam logic [2:0] PKT_SCHED = 3'b010;
  localparam logic [2:0] PKT_EBND  = 3'b011;
  localparam logic [2:0] PKT_NEWR  = 3'b111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DISC = 2'd1, S_CLUS = 2'd2, S_SCHED = 2'd3} state_t;

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] hops_nxt, slot_nxt, thr_nxt, hops_inc, e_diff, thr_hyst;
  logic [DATA_W:0]   thr_sum;
  logic              role_nxt, low_nxt, hello_acc, ebound, trig;
  logic              s1_vld;
  logic [DATA_W-1:0] s1_energy, s1_hops, s1_shift, q_val;

  assign myNodeID = NODE_ID;
  assign state    = state_q;
  assign hops_inc = hops + DATA_W'(1);
  assign e_diff   = e_max - e_min;

  assign hello_acc = en_MNI && (fPktType == PKT_HELLO) && (hops != ONES) && (hops_inc < hopsFromSink);
  assign ebound    = en_MNI && (fPktType == PKT_EBND);

  // Release level for the hysteresis band, clamped so a threshold near full scale still clears.
  assign thr_sum  = {1'b0, e_thr} + (DATA_W+1)'(HYST);
  assign thr_hyst = thr_sum[DATA_W] ? ONES : thr_sum[DATA_W-1:0];

  always_comb begin
    state_nxt = state_q;
    hops_nxt  = hopsFromSink;
    role_nxt  = role;
    slot_nxt  = myTimeslot;
    thr_nxt   = e_thr;
    low_nxt   = low_E;

    if (hello_acc) begin
      hops_nxt = hops_inc;
      if (state_q == S_IDLE) state_nxt = S_DISC;
    end
    if (ebound) thr_nxt = (e_max >= e_min) ? e_min + (e_diff >> THR_SHIFT) : e_min;

    if (en_MNI) begin
      case (fPktType)
        PKT_CHANN: if (state_q == S_DISC) begin
          role_nxt  = (ch_ID == NODE_ID);
          state_nxt = S_CLUS;
        end
        PKT_SCHED: if (state_q == S_CLUS) begin
          slot_nxt  = timeslot;
          state_nxt = S_SCHED;
        end
        PKT_NEWR: if (state_q != S_IDLE) begin
          role_nxt  = 1'b0;
          slot_nxt  = '0;
          state_nxt = S_DISC;
        end
        default: ;
      endcase
    end

    if (energy < e_thr)          low_nxt = 1'b1;
    else if (energy >= thr_hyst) low_nxt = 1'b0;
  end

  assign trig = hello_acc | ebound | (low_nxt != low_E);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hopsFromSink <= ONES;
      role         <= 1'b0;
      myTimeslot   <= '0;
      e_thr        <= '0;
      low_E        <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      hopsFromSink <= hops_nxt;
      role         <= role_nxt;
      myTimeslot   <= slot_nxt;
      e_thr        <= thr_nxt;
      low_E        <= low_nxt;
    end
  end

  // Stage 2 arithmetic: unreachable-sink or underflow both give Q = 0.
  assign s1_shift = s1_energy >> Q_SHIFT;
  assign q_val    = ((s1_hops == ONES) || (s1_shift <= s1_hops)) ? '0 : s1_shift - s1_hops;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_energy <= '0;
      s1_hops   <= '0;
      myQValue  <= '0;
      q_valid   <= 1'b0;
    end else begin
      s1_vld  <= trig;
      q_valid <= s1_vld;
      if (trig) begin
        s1_energy <= energy;
        s1_hops   <= hops_nxt;
      end
      if (s1_vld) myQValue <= q_val;
    end
  end

endmodule

// File: tb/tb_node_info_ctrl.sv
// Directed bench for node_info_ctrl; Q results checked through a cycle-stamped scoreboard queue.
module tb_node_info_ctrl;

  localparam logic [2:0] HELLO = 3'b000;
  localparam logic [2:0] CHANN = 3'b001;
  localparam logic [2:0] SCHED = 3'b010;
  localparam logic [2:0] EBND  = 3'b011;
  localparam logic [2:0] NEWR  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_MNI;
  logic [2:0]  fPktType;
  logic [15:0] e_max, e_min, energy, ch_ID, hops, timeslot;
  logic [15:0] myNodeID, hopsFromSink, myQValue, myTimeslot, e_thr;
  logic        role, low_E, q_valid;
  logic [1:0]  state;

  typedef struct {
    logic [15:0] q;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  node_info_ctrl dut (
    .clk(clk), .rst(rst), .en_MNI(en_MNI), .fPktType(fPktType),
    .e_max(e_max), .e_min(e_min), .energy(energy), .ch_ID(ch_ID),
    .hops(hops), .timeslot(timeslot), .myNodeID(myNodeID),
    .hopsFromSink(hopsFromSink), .myQValue(myQValue), .myTimeslot(myTimeslot),
    .e_thr(e_thr), .role(role), .low_E(low_E), .state(state), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Q-value monitor: each q_valid pulse must match the oldest expectation, on its due cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (q_valid) begin
      if (sb.size() == 0) chk("q_unexpected", {31'd0, q_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("q_cycle", cyc, e.due);
        chk("q_value", {16'd0, myQValue}, {16'd0, e.q});
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("q_missing", {31'd0, q_valid}, 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic push_q(input logic [15:0] q);
    exp_t e;
    e.q   = q;
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic pkt(input logic [2:0] t, input logic [15:0] v, input bit tr, input logic [15:0] qe);
    @(negedge clk);
    en_MNI   = 1'b1;
    fPktType = t;
    case (t)
      HELLO:   hops     = v;
      CHANN:   ch_ID    = v;
      SCHED:   timeslot = v;
      default: ;
    endcase
    if (tr) push_q(qe);
    @(negedge clk);
    en_MNI = 1'b0;
  endtask

  task automatic set_energy(input logic [15:0] v, input bit tr, input logic [15:0] qe);
    @(negedge clk);
    energy = v;
    if (tr) push_q(qe);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hops"},  {16'd0, hopsFromSink}, 32'h0000_FFFF);
    chk({tag, "_state"}, {30'd0, state}, 32'd0);
    chk({tag, "_q"},     {16'd0, myQValue}, 32'd0);
    chk({tag, "_slot"},  {16'd0, myTimeslot}, 32'd0);
    chk({tag, "_thr"},   {16'd0, e_thr}, 32'd0);
    chk({tag, "_role"},  {31'd0, role}, 32'd0);
    chk({tag, "_lowE"},  {31'd0, low_E}, 32'd0);
    chk({tag, "_qv"},    {31'd0, q_valid}, 32'd0);
    chk({tag, "_id"},    {16'd0, myNodeID}, 32'h0000_000C);
  endtask

  initial begin
    rst = 1'b1; en_MNI = 1'b0; fPktType = 3'b000;
    e_max = '0; e_min = '0; energy = '0; ch_ID = '0; hops = '0; timeslot = '0;
    #3;
    check_reset("rst0");
    @(negedge clk);
    rst    = 1'b0;
    energy = 16'h1000;

    // Hop discovery: 0x1000>>4 = 256
    pkt(HELLO, 16'd3, 1'b1, 16'd252);
    chk("hello3_hops", {16'd0, hopsFromSink}, 32'd4);
    chk("hello3_state", {30'd0, state}, 32'd1);
    pkt(HELLO, 16'd5, 1'b0, 16'd0);
    chk("hello5_hops", {16'd0, hopsFromSink}, 32'd4);
    pkt(HELLO, 16'd1, 1'b1, 16'd254);
    chk("hello1_hops", {16'd0, hopsFromSink}, 32'd2);
    pkt(HELLO, 16'hFFFF, 1'b0, 16'd0);
    chk("hello_ones_hops", {16'd0, hopsFromSink}, 32'd2);

    // Clustering
    pkt(CHANN, 16'h000C, 1'b0, 16'd0);
    chk("chann_me_role", {31'd0, role}, 32'd1);
    chk("chann_me_state", {30'd0, state}, 32'd2);
    pkt(NEWR, 16'd0, 1'b0, 16'd0);
    chk("newr_role", {31'd0, role}, 32'd0);
    chk("newr_state", {30'd0, state}, 32'd1);
    chk("newr_hops", {16'd0, hopsFromSink}, 32'd2);
    pkt(CHANN, 16'h0005, 1'b0, 16'd0);
    chk("chann_other_role", {31'd0, role}, 32'd0);
    chk("chann_other_state", {30'd0, state}, 32'd2);

    // Scheduling
    pkt(SCHED, 16'd7, 1'b0, 16'd0);
    chk("sched7_slot", {16'd0, myTimeslot}, 32'd7);
    chk("sched7_state", {30'd0, state}, 32'd3);
    pkt(SCHED, 16'd9, 1'b0, 16'd0);
    chk("sched9_slot", {16'd0, myTimeslot}, 32'd7);
    chk("sched9_state", {30'd0, state}, 32'd3);
    pkt(NEWR, 16'd0, 1'b0, 16'd0);
    chk("newr2_slot", {16'd0, myTimeslot}, 32'd0);
    chk("newr2_state", {30'd0, state}, 32'd1);

    // Energy threshold and hysteresis: thr = 200 + 800/4 = 400, release at 408
    e_max = 16'd1000; e_min = 16'd200;
    pkt(EBND, 16'd0, 1'b1, 16'd254);
    chk("ebound_thr", {16'd0, e_thr}, 32'd400);
    set_energy(16'd399, 1'b1, 16'd22);
    chk("e399_lowE", {31'd0, low_E}, 32'd1);
    set_energy(16'd405, 1'b0, 16'd0);
    chk("e405_lowE", {31'd0, low_E}, 32'd1);
    set_energy(16'd408, 1'b1, 16'd23);
    chk("e408_lowE", {31'd0, low_E}, 32'd0);
    e_max = 16'd100; e_min = 16'd300;
    pkt(EBND, 16'd0, 1'b1, 16'd23);
    chk("ebound_inv_thr", {16'd0, e_thr}, 32'd300);

    // Q from a low_E trigger: 0x100>>4 = 16, minus 2 hops
    set_energy(16'h0100, 1'b1, 16'd14);
    chk("e100_lowE", {31'd0, low_E}, 32'd1);
    repeat (2) @(negedge clk);
    chk("q14_hold", {16'd0, myQValue}, 32'd14);

    // Reset while a Q result is in flight: the pending result must never appear
    pkt(HELLO, 16'd0, 1'b0, 16'd0);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;

    pkt(SCHED, 16'd9, 1'b0, 16'd0);
    chk("sched_idle_state", {30'd0, state}, 32'd0);
    chk("sched_idle_slot", {16'd0, myTimeslot}, 32'd0);
    energy = 16'h0010;
    pkt(HELLO, 16'd4, 1'b1, 16'd0);
    chk("hello4_hops", {16'd0, hopsFromSink}, 32'd5);
    chk("hello4_state", {30'd0, state}, 32'd1);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
